// File: rtl/fifo_wr_arbiter_if.sv
// Requester and FIFO write-side bundle for fifo_wr_arbiter.
// master: arbiter side; slave: requesters plus FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_last;
  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_ready;
  logic                          fifo_wr_en;
  logic [FIFO_WIDTH-1:0]         fifo_data_in;
  logic                          fifo_full;
  logic                          fifo_almostfull;
  logic                          fifo_wr_ack;
  logic                          fifo_overflow;

  modport master (
    input  req_valid,
    input  req_last,
    input  req_data,
    output req_ready,
    output fifo_wr_en,
    output fifo_data_in,
    input  fifo_full,
    input  fifo_almostfull,
    input  fifo_wr_ack,
    input  fifo_overflow
  );

  modport slave (
    output req_valid,
    output req_last,
    output req_data,
    input  req_ready,
    input  fifo_wr_en,
    input  fifo_data_in,
    output fifo_full,
    output fifo_almostfull,
    output fifo_wr_ack,
    output fifo_overflow
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, packet-locked arbiter for one FIFO write port.
// Ports: clk, rst_n, bus (requesters + FIFO), grant_id, busy, ack_cnt, drop_cnt.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_WIDTH = 16,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  fifo_wr_arbiter_if.master          bus,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic [CNT_WIDTH-1:0]       ack_cnt,
  output logic [CNT_WIDTH-1:0]       drop_cnt
);

  localparam int PW = $clog2(NUM_REQ);
  localparam logic [PW-1:0] LAST_IDX = PW'(NUM_REQ - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic {ARB, BURST} state_t;

  state_t                 state_q, state_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]          grant_id_q, grant_id_d;
  logic                   wr_en_q, wr_en_d;
  logic [FIFO_WIDTH-1:0]  data_q, data_d;
  logic [CNT_WIDTH-1:0]   ack_q, ack_d;
  logic [CNT_WIDTH-1:0]   drop_q, drop_d;

  logic                   win_found;
  logic [PW-1:0]          win_idx;
  logic [PW-1:0]          sel_idx;
  logic                   sel_valid;
  logic                   sel_last;
  logic [FIFO_WIDTH-1:0]  sel_data;
  logic                   stall;
  logic                   xfer;
  logic [NUM_REQ-1:0]     ready;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      rr_ptr_q   <= LAST_IDX;
      grant_id_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q <= 1'b0;
      data_q  <= '0;
      ack_q   <= '0;
      drop_q  <= '0;
    end else begin
      wr_en_q <= wr_en_d;
      data_q  <= data_d;
      ack_q   <= ack_d;
      drop_q  <= drop_d;
    end
  end

  // first valid requester after rr_ptr, wrapping
  always_comb begin : p_win
    int j;
    win_found = 1'b0;
    win_idx   = '0;
    j         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      j = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!win_found && bus.req_valid[j]) begin
        win_found = 1'b1;
        win_idx   = PW'(j);
      end
    end
  end

  always_comb begin
    sel_idx   = (state_q == BURST) ? grant_id_q : win_idx;
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == PW'(i)) begin
        sel_valid = bus.req_valid[i];
        sel_last  = bus.req_last[i];
        sel_data  = bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
      end
    end
  end

  // an in-flight write may consume the last free slot
  assign stall = bus.fifo_full | (bus.fifo_almostfull & wr_en_q);

  // output comb
  always_comb begin
    xfer  = rst_n & ~stall & sel_valid;
    ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready[i] = xfer & (sel_idx == PW'(i));
    end
  end

  // next-state comb
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_id_d = grant_id_q;
    unique case (state_q)
      ARB: begin
        if (xfer) begin
          grant_id_d = win_idx;
          rr_ptr_d   = win_idx;
          if (!sel_last) state_d = BURST;
        end
      end
      BURST: begin
        if (xfer && sel_last) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    wr_en_d = xfer;
    data_d  = xfer ? sel_data : data_q;
    ack_d   = ack_q;
    drop_d  = drop_q;
    if (bus.fifo_wr_ack && ack_q != CNT_MAX) ack_d = ack_q + CNT_ONE;
    if (bus.fifo_overflow && drop_q != CNT_MAX) drop_d = drop_q + CNT_ONE;
  end

  assign bus.req_ready    = ready;
  assign bus.fifo_wr_en   = wr_en_q;
  assign bus.fifo_data_in = data_q;
  assign grant_id         = grant_id_q;
  assign busy             = (state_q == BURST);
  assign ack_cnt          = ack_q;
  assign drop_cnt         = drop_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic
// against a request-level reference model and a depth-8 FIFO stand-in.
module tb_fifo_wr_arbiter;
  localparam int N = 4;
  localparam int W = 16;
  localparam int CW = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.NUM_REQ(N), .FIFO_WIDTH(W)) bus();
  logic [1:0]    grant_id;
  logic          busy;
  logic [CW-1:0] ack_cnt;
  logic [CW-1:0] drop_cnt;

  fifo_wr_arbiter #(.NUM_REQ(N), .FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus),
    .grant_id(grant_id),
    .busy(busy),
    .ack_cnt(ack_cnt),
    .drop_cnt(drop_cnt)
  );

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;

  bit m_locked;
  int m_gid, m_rr, m_ack, m_drop;
  bit m_wr;
  logic [W-1:0] m_data;

  bit emu;
  bit rd;
  int fcount;
  int plen[N];
  int beats[N];
  int seq[N];
  int q_win[$];
  int wr_pulses;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0;
    m_gid = 0;
    m_rr = N - 1;
    m_wr = 0;
    m_data = '0;
    m_ack = 0;
    m_drop = 0;
    fcount = 0;
    bus.fifo_full = 0;
    bus.fifo_almostfull = 0;
    bus.fifo_wr_ack = 0;
    bus.fifo_overflow = 0;
    for (int i = 0; i < N; i++) beats[i] = 0;
  endtask

  // who should get ready this cycle, -1 for nobody
  function automatic int pick();
    if (!rst_n) return -1;
    if (bus.fifo_full || (bus.fifo_almostfull && m_wr)) return -1;
    if (m_locked) return bus.req_valid[m_gid] ? m_gid : -1;
    for (int k = 1; k <= N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (bus.req_valid[j]) return j;
    end
    return -1;
  endfunction

  task automatic drive(logic [N-1:0] vm);
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = vm[i];
      bus.req_last[i] = (beats[i] == plen[i] - 1);
      if (vm[i]) bus.req_data[i*W +: W] = W'((i << 12) | (seq[i] & 'hfff));
      else bus.req_data[i*W +: W] = {W{1'bx}};
    end
  endtask

  task automatic tick();
    int w;
    logic [N-1:0] er;
    logic wr_s;
    @(negedge clk);
    w = pick();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", 32'(bus.req_ready), 32'(er));
    wr_s = bus.fifo_wr_en;
    if (wr_s === 1'b1) wr_pulses++;
    @(posedge clk);
    #1;
    if (w >= 0) begin
      m_data = bus.req_data[w*W +: W];
      m_wr = 1;
      m_gid = w;
      m_rr = w;
      m_locked = !bus.req_last[w];
      q_win.push_back(w);
      seq[w]++;
      beats[w] = bus.req_last[w] ? 0 : beats[w] + 1;
    end else begin
      m_wr = 0;
    end
    if (bus.fifo_wr_ack && m_ack < 255) m_ack++;
    if (bus.fifo_overflow && m_drop < 255) m_drop++;
    if (emu) begin
      bus.fifo_wr_ack = 0;
      bus.fifo_overflow = 0;
      if (wr_s === 1'b1) begin
        if (fcount < DEPTH) begin
          fcount++;
          bus.fifo_wr_ack = 1;
        end else begin
          bus.fifo_overflow = 1;
        end
      end
      if (rd && fcount > 0) fcount--;
      bus.fifo_full = (fcount == DEPTH);
      bus.fifo_almostfull = (fcount == DEPTH - 1);
    end
    chk("wr_en", 32'(bus.fifo_wr_en), 32'(m_wr));
    chk("data_in", 32'(bus.fifo_data_in), 32'(m_data));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    chk("busy", 32'(busy), 32'(m_locked));
    chk("ack_cnt", 32'(ack_cnt), 32'(m_ack));
    chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic do_reset();
    rst_n = 0;
    emu = 0;
    rd = 0;
    model_reset();
    bus.req_valid = '1;
    bus.req_last = '1;
    bus.req_data = '0;
    #1;
    chk("rst_ready", 32'(bus.req_ready), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", 32'(bus.fifo_wr_en), 0);
    chk("rst_data", 32'(bus.fifo_data_in), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ack", 32'(ack_cnt), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    bus.req_valid = '0;
    bus.req_last = '0;
    rst_n = 1;
  endtask

  initial begin
    int e1[5];
    int e2[6];
    for (int i = 0; i < N; i++) begin
      plen[i] = 1;
      seq[i] = 0;
    end
    wr_pulses = 0;
    do_reset();

    // all requesters stream single-beat packets
    e1 = '{0, 1, 2, 3, 0};
    q_win.delete();
    repeat (5) begin
      drive(4'hf);
      tick();
    end
    chk("s1_len", 32'(q_win.size()), 5);
    for (int i = 0; i < 5; i++)
      if (i < q_win.size()) chk("s1_order", 32'(q_win[i]), 32'(e1[i]));

    // req 2 sends a locked 4-beat packet
    do_reset();
    plen = '{1, 1, 4, 1};
    e2 = '{2, 2, 2, 2, 3, 1};
    q_win.delete();
    drive(4'b0100);
    tick();
    repeat (5) begin
      drive(4'b1110);
      tick();
    end
    chk("s2_len", 32'(q_win.size()), 6);
    for (int i = 0; i < 6; i++)
      if (i < q_win.size()) chk("s2_order", 32'(q_win[i]), 32'(e2[i]));

    // fill a depth-8 FIFO with no reads
    do_reset();
    emu = 1;
    plen = '{2, 3, 1, 2};
    wr_pulses = 0;
    repeat (30) begin
      drive(4'hf);
      tick();
    end
    chk("fill_pulses", 32'(wr_pulses), 8);
    chk("fill_count", 32'(fcount), 8);
    chk("fill_ack", 32'(ack_cnt), 8);
    chk("fill_drop", 32'(drop_cnt), 0);

    // one read frees one slot: exactly one more write
    wr_pulses = 0;
    rd = 1;
    drive(4'hf);
    tick();
    rd = 0;
    repeat (6) begin
      drive(4'hf);
      tick();
    end
    chk("af_pulses", 32'(wr_pulses), 1);
    chk("af_count", 32'(fcount), 8);

    // random traffic, gaps and reads
    repeat (400) begin
      rd = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < N; i++)
        if (beats[i] == 0) plen[i] = $urandom_range(1, 4);
      drive(N'($urandom));
      tick();
    end
    rd = 0;
    chk("rand_drop", 32'(drop_cnt), 0);

    // reset in the middle of a req 1 burst
    do_reset();
    plen = '{1, 4, 1, 1};
    drive(4'b0010);
    tick();
    drive(4'b0010);
    tick();
    chk("mid_busy_pre", 32'(busy), 1);
    #2;
    rst_n = 0;
    #1;
    chk("mid_ready", 32'(bus.req_ready), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_wr_en", 32'(bus.fifo_wr_en), 0);
    chk("mid_data", 32'(bus.fifo_data_in), 0);
    chk("mid_gid", 32'(grant_id), 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    q_win.delete();
    drive(4'b0011);
    tick();
    chk("mid_len", 32'(q_win.size()), 1);
    if (q_win.size() > 0) chk("mid_winner", 32'(q_win[0]), 0);

    // counter saturation
    do_reset();
    bus.fifo_wr_ack = 1;
    repeat (300) tick();
    bus.fifo_wr_ack = 0;
    chk("ack_sat", 32'(ack_cnt), 255);
    bus.fifo_overflow = 1;
    repeat (260) tick();
    bus.fifo_overflow = 0;
    tick();
    chk("drop_sat", 32'(drop_cnt), 255);
    chk("ack_hold", 32'(ack_cnt), 255);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
